// File: rtl/iir_pkg.sv
// Shared types and default sizing for the cascaded-SOS IIR sequencer.
package iir_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam int IIR_N_SAMPLES = 2048;
  localparam int IIR_ADDR_W    = 11;
  localparam int IIR_DATA_W    = 24;

endpackage

// File: rtl/iir_stable_det.sv
// Output stability detector: counts consecutive final-stage outputs whose step
// from the previous output stays within STABLE_THR; flag is sticky until clr.
module iir_stable_det import iir_pkg::*; #(
  parameter int DATA_W     = IIR_DATA_W,
  parameter int STABLE_THR = 16,
  parameter int STABLE_CNT = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] data,
  output logic                     stable
);

  localparam int RW = $clog2(STABLE_CNT + 1);

  logic signed [DATA_W-1:0] prev;
  logic                     have_prev;
  logic [RW-1:0]            run_cnt;
  logic signed [DATA_W:0]   diff;
  logic [DATA_W:0]          mag;
  logic                     settled;

  // One extra bit keeps the difference of two full-range samples exact.
  always_comb begin
    diff    = {data[DATA_W-1], data} - {prev[DATA_W-1], prev};
    mag     = diff[DATA_W] ? -diff : diff;
    settled = (mag <= (DATA_W+1)'(STABLE_THR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '0;
      have_prev <= 1'b0;
      run_cnt   <= '0;
      stable    <= 1'b0;
    end else if (clr) begin
      have_prev <= 1'b0;
      run_cnt   <= '0;
      stable    <= 1'b0;
    end else if (valid) begin
      prev      <= data;
      have_prev <= 1'b1;
      if (have_prev) begin
        if (!settled) begin
          run_cnt <= '0;
        end else if (run_cnt != RW'(STABLE_CNT)) begin
          run_cnt <= run_cnt + 1'b1;
          if (run_cnt == RW'(STABLE_CNT - 1)) stable <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/iir_seq_ctrl.sv
// Frame sequencer for the SOS IIR cascade: flush, admit N_SAMPLES, count outputs, drain.
// Optional stability detector built when IIR_STABLE_DET_EN is defined.
module iir_seq_ctrl import iir_pkg::*; #(
  parameter int N_SAMPLES  = IIR_N_SAMPLES,
  parameter int ADDR_W     = IIR_ADDR_W,
  parameter int DATA_W     = IIR_DATA_W,
  parameter int DRAIN_MAX  = 64,
  parameter int STABLE_THR = 16,
  parameter int STABLE_CNT = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic                     sos_valid,
  input  logic signed [DATA_W-1:0] sos_data,
  output logic                     flush,
  output logic                     sample_en,
  output logic                     busy,
  output logic [ADDR_W-1:0]        addr,
  output logic                     out_valid,
  output logic                     filter_done,
  output logic                     timeout,
  output logic                     stable_out
);

  // Counters carry one bit beyond ADDR_W so they can hold N_SAMPLES itself.
  localparam int CW = ADDR_W + 1;
  localparam int DW = $clog2(DRAIN_MAX + 1);

  seq_state_t     state, state_nxt;
  logic [CW-1:0]  in_cnt, out_cnt;
  logic [DW-1:0]  drain_cnt;
  logic           timeout_q, done_q;
  logic           frame_start, in_last, out_full, drain_exp, drain_end;

  assign frame_start = (state == IDLE) && start;
  assign in_last     = (in_cnt == CW'(N_SAMPLES - 1));
  assign out_full    = (out_cnt == CW'(N_SAMPLES));
  assign drain_exp   = (drain_cnt == DW'(DRAIN_MAX));
  assign drain_end   = (state == DRAIN) && (out_full || drain_exp);

  assign addr        = out_cnt[ADDR_W-1:0];
  assign timeout     = timeout_q;
  assign filter_done = done_q;

  always_comb begin
    state_nxt = state;
    flush     = 1'b0;
    sample_en = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        flush     = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        sample_en = in_valid;
        out_valid = sos_valid && !out_full;
        if (in_valid && in_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = sos_valid && !out_full;
        if (out_full || drain_exp) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Completion takes priority over timeout when both land on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_cnt    <= '0;
      out_cnt   <= '0;
      drain_cnt <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= drain_end;
      if (frame_start) begin
        in_cnt    <= '0;
        out_cnt   <= '0;
        timeout_q <= 1'b0;
      end else begin
        if (sample_en) in_cnt  <= in_cnt + 1'b1;
        if (out_valid) out_cnt <= out_cnt + 1'b1;
        if (drain_end && !out_full) timeout_q <= 1'b1;
      end
      if (state != DRAIN)  drain_cnt <= '0;
      else if (!drain_exp) drain_cnt <= drain_cnt + 1'b1;
    end
  end

`ifdef IIR_STABLE_DET_EN
  iir_stable_det #(
    .DATA_W     (DATA_W),
    .STABLE_THR (STABLE_THR),
    .STABLE_CNT (STABLE_CNT)
  ) u_stable_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (frame_start),
    .valid  (out_valid),
    .data   (sos_data),
    .stable (stable_out)
  );
`else
  localparam int unused_cfg = STABLE_THR + STABLE_CNT;
  logic unused_data;
  assign unused_data = ^sos_data;
  assign stable_out  = 1'b0;
`endif

endmodule

// File: tb/tb_iir_seq_ctrl.sv
// Randomized frame bench for iir_seq_ctrl against a cycle-count reference model.
// Stability expectations follow IIR_STABLE_DET_EN.
module tb_iir_seq_ctrl;

  localparam int N    = 64;
  localparam int AW   = 6;
  localparam int DW   = 24;
  localparam int DMAX = 64;
  localparam int THR  = 16;
  localparam int SCNT = 32;
  localparam int MAXC = 600;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0, in_valid = 1'b0, sos_valid = 1'b0;
  logic signed [DW-1:0] sos_data = '0;
  logic                 flush, sample_en, busy, out_valid, filter_done, timeout, stable_out;
  logic [AW-1:0]        addr;

  int checks = 0;
  int passed = 0;

  // Per-cycle traces of one frame: {stable, timeout, busy, done, out_valid, sample_en, flush}
  logic [6:0]    obs_sig [MAXC];
  logic [6:0]    exp_sig [MAXC];
  logic [AW-1:0] obs_addr[MAXC];
  logic [AW-1:0] exp_addr[MAXC];
  int            f_out_cyc[N];
  int            ncyc, f_done, f_drain, f_n_done;
  bit            f_timeout;
  bit            m_to, m_stable;

  always #5 clk = ~clk;

  iir_seq_ctrl #(
    .N_SAMPLES(N), .ADDR_W(AW), .DATA_W(DW),
    .DRAIN_MAX(DMAX), .STABLE_THR(THR), .STABLE_CNT(SCNT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .sos_valid(sos_valid), .sos_data(sos_data), .flush(flush),
    .sample_en(sample_en), .busy(busy), .addr(addr), .out_valid(out_valid),
    .filter_done(filter_done), .timeout(timeout), .stable_out(stable_out)
  );

  // Runs one frame from IDLE; the SOS cascade is modelled as a 3-cycle delay line.
  task automatic run_frame(input int pct, input int drop0, input int drop1,
                           input bit hold, input bit jitter, input int step_idx);
    bit                   sv[MAXC];
    logic signed [DW-1:0] sd[MAXC];
    int acc_in, acc_out, done, drain, run, d, j, k;
    bit tmo, have_prev, se_e, ov_e, act;
    logic signed [DW-1:0] prev_y;
    for (int i = 0; i < MAXC; i++) begin sv[i] = 1'b0; sd[i] = '0; end
    acc_in = 0; acc_out = 0; done = -1; drain = -1; run = 0;
    tmo = 1'b0; have_prev = 1'b0; prev_y = '0; f_n_done = 0;
    for (k = 0; k < MAXC - 4; k++) begin
      @(posedge clk); #1;
      start     = (k == 0) || (hold && (done < 0 || k <= done));
      in_valid  = ($urandom_range(0, 99) < pct);
      sos_valid = sv[k];
      sos_data  = sd[k];
      act  = (k >= 2) && (done < 0 || k < done);
      se_e = (k >= 2) && (acc_in < N) && in_valid;
      ov_e = act && sv[k] && (acc_out < N);
      exp_sig[k]  = {m_stable, m_to, (k >= 1 && (done < 0 || k <= done)), (k == done), ov_e, se_e, (k == 1)};
      exp_addr[k] = ov_e ? AW'(acc_out) : '0;
      #3;
      obs_sig[k]  = {stable_out, timeout, busy, filter_done, out_valid, sample_en, flush};
      obs_addr[k] = out_valid ? addr : '0;
      if (filter_done) f_n_done++;
      if (k == 0) begin m_to = 1'b0; m_stable = 1'b0; end
      if (se_e) begin
        if (acc_in != drop0 && acc_in != drop1) begin
          j = $urandom_range(0, 10);
          sv[k+3] = 1'b1;
          sd[k+3] = jitter ? DW'(1000 + ((acc_in >= step_idx) ? 500 : 0) + j - 5) : DW'($urandom);
        end
        acc_in++;
        if (acc_in == N) drain = k + 1;
      end
      if (ov_e) begin
        if (have_prev) begin
          d = int'(sd[k]) - int'(prev_y);
          if (d < 0) d = -d;
          if (d <= THR) run = (run < SCNT) ? run + 1 : run;
          else          run = 0;
`ifdef IIR_STABLE_DET_EN
          if (run >= SCNT) m_stable = 1'b1;
`endif
        end
        prev_y = sd[k]; have_prev = 1'b1;
        f_out_cyc[acc_out] = k;
        acc_out++;
      end
      if (drain >= 0 && done < 0 && k + 1 >= drain) begin
        if (acc_out == N) done = k + 2;
        else if (k + 1 - drain == DMAX) begin done = k + 2; tmo = 1'b1; end
      end
      if (tmo && k + 1 == done) m_to = 1'b1;
      if (done >= 0 && k == done + 3) break;
    end
    ncyc = k; f_done = done; f_drain = drain; f_timeout = tmo;
    if (done < 0 || k >= MAXC - 4) begin
      checks++;
      $display("[TB] FAIL frame_bound: frame did not finish, got no done within %0d cycles, required done", MAXC);
      if (ncyc >= MAXC) ncyc = MAXC - 1;
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; sos_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; sos_valid = 1'b0;
    #12;
    checks++;
    if ({flush, sample_en, busy, addr, out_valid, filter_done, timeout, stable_out} !== '0)
      $display("[TB] FAIL reset_outputs: got %b, required all zero",
               {flush, sample_en, busy, addr, out_valid, filter_done, timeout, stable_out});
    else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    m_to = 1'b0; m_stable = 1'b0;
  endtask

  task automatic test_basic();
    int first_done, last_ov;
    run_frame(100, -1, -1, 1'b0, 1'b0, N);
    first_done = -1; last_ov = -1;
    for (int k = 0; k <= ncyc; k++) begin
      checks++;
      if (obs_sig[k] !== exp_sig[k] || obs_addr[k] !== exp_addr[k])
        $display("[TB] FAIL basic_trace cyc=%0d: got sig=%b addr=%0d, required sig=%b addr=%0d",
                 k, obs_sig[k], obs_addr[k], exp_sig[k], exp_addr[k]);
      else passed++;
      if (obs_sig[k][3] && first_done < 0) first_done = k;
      if (obs_sig[k][2]) last_ov = k;
    end
    checks++;
    if (first_done !== last_ov + 2 || f_n_done !== 1)
      $display("[TB] FAIL basic_done: got done at %0d count %0d, required at %0d count 1",
               first_done, f_n_done, last_ov + 2);
    else passed++;
  endtask

  task automatic test_bursty();
    run_frame(50, -1, -1, 1'b0, 1'b0, N);
    for (int k = 0; k <= ncyc; k++) begin
      checks++;
      if (obs_sig[k] !== exp_sig[k] || obs_addr[k] !== exp_addr[k])
        $display("[TB] FAIL bursty_trace cyc=%0d: got sig=%b addr=%0d, required sig=%b addr=%0d",
                 k, obs_sig[k], obs_addr[k], exp_sig[k], exp_addr[k]);
      else passed++;
    end
  endtask

  task automatic test_lost_outputs();
    int first_done, last_addr;
    run_frame(100, 5, 9, 1'b0, 1'b0, N);
    first_done = -1; last_addr = -1;
    for (int k = 0; k <= ncyc; k++) begin
      checks++;
      if (obs_sig[k] !== exp_sig[k] || obs_addr[k] !== exp_addr[k])
        $display("[TB] FAIL lost_trace cyc=%0d: got sig=%b addr=%0d, required sig=%b addr=%0d",
                 k, obs_sig[k], obs_addr[k], exp_sig[k], exp_addr[k]);
      else passed++;
      if (obs_sig[k][3] && first_done < 0) first_done = k;
      if (obs_sig[k][2]) last_addr = int'(obs_addr[k]);
    end
    checks++;
    if (first_done !== f_drain + DMAX + 1 || last_addr !== N - 3 || timeout !== 1'b1)
      $display("[TB] FAIL lost_timeout: got done %0d last addr %0d timeout %b, required done %0d addr %0d timeout 1",
               first_done, last_addr, timeout, f_drain + DMAX + 1, N - 3);
    else passed++;
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1 start = 1'b1; in_valid = 1'b1; sos_valid = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (42) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || sample_en !== 1'b1)
      $display("[TB] FAIL midreset_running: got busy %b sample_en %b, required 1 1", busy, sample_en);
    else passed++;
    rst_n = 1'b0; #1;
    checks++;
    if ({flush, sample_en, busy, addr, out_valid, filter_done, timeout, stable_out} !== '0)
      $display("[TB] FAIL midreset_outputs: got %b, required all zero",
               {flush, sample_en, busy, addr, out_valid, filter_done, timeout, stable_out});
    else passed++;
    @(posedge clk); #1 rst_n = 1'b1; in_valid = 1'b0;
    m_to = 1'b0; m_stable = 1'b0;
    run_frame(70, -1, -1, 1'b0, 1'b0, N);
    for (int k = 0; k <= ncyc; k++) begin
      checks++;
      if (obs_sig[k] !== exp_sig[k] || obs_addr[k] !== exp_addr[k])
        $display("[TB] FAIL rerun_trace cyc=%0d: got sig=%b addr=%0d, required sig=%b addr=%0d",
                 k, obs_sig[k], obs_addr[k], exp_sig[k], exp_addr[k]);
      else passed++;
    end
  endtask

  task automatic test_start_abuse();
    run_frame(80, -1, -1, 1'b1, 1'b0, N);
    for (int k = 0; k <= ncyc; k++) begin
      checks++;
      if (obs_sig[k] !== exp_sig[k] || obs_addr[k] !== exp_addr[k])
        $display("[TB] FAIL abuse_trace cyc=%0d: got sig=%b addr=%0d, required sig=%b addr=%0d",
                 k, obs_sig[k], obs_addr[k], exp_sig[k], exp_addr[k]);
      else passed++;
    end
    checks++;
    if (f_n_done !== 1 || busy !== 1'b0)
      $display("[TB] FAIL abuse_single: got %0d done pulses busy %b, required 1 pulse busy 0", f_n_done, busy);
    else passed++;
  endtask

  task automatic test_stability(input int step_idx, input int rise_out);
    int rise;
    run_frame(100, -1, -1, 1'b0, 1'b1, step_idx);
    rise = -1;
    for (int k = 0; k <= ncyc; k++) begin
      checks++;
      if (obs_sig[k] !== exp_sig[k] || obs_addr[k] !== exp_addr[k])
        $display("[TB] FAIL stable_trace cyc=%0d: got sig=%b addr=%0d, required sig=%b addr=%0d",
                 k, obs_sig[k], obs_addr[k], exp_sig[k], exp_addr[k]);
      else passed++;
      if (obs_sig[k][6] && rise < 0) rise = k;
    end
    checks++;
`ifdef IIR_STABLE_DET_EN
    if (rise !== f_out_cyc[rise_out] + 1)
      $display("[TB] FAIL stable_rise: got rise at %0d, required %0d", rise, f_out_cyc[rise_out] + 1);
    else passed++;
`else
    if (rise !== -1)
      $display("[TB] FAIL stable_off: got rise at %0d, required never (rise_out %0d)", rise, rise_out);
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bursty();
    test_lost_outputs();
    test_mid_reset();
    test_start_abuse();
    test_stability(N, SCNT);
    test_stability(20, 20 + SCNT);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/iir_seq_ctrl.md
# iir_seq_ctrl

Frame sequencer for the cascaded-SOS IIR datapath inside `opti_top`. After a `start` pulse it flushes the filter state, admits exactly `N_SAMPLES` input samples, and counts the final-stage outputs while supplying their write address. It then drains the SOS pipeline and reports completion, timeout and output stability. It sits between the sample source and the SOS cascade, and its outputs drive `addr`, `data_out_valid`, `filter_done` and `stable_out` at top level.

## Interface
- `N_SAMPLES`, 2048: samples per frame.
- `ADDR_W`, 11: address/counter width; must satisfy 2^ADDR_W ≥ `N_SAMPLES`.
- `DATA_W`, 24: signed sample width.
- `DRAIN_MAX`, 64: maximum cycles in DRAIN before timeout.
- `STABLE_THR`, 16: maximum |y[n]−y[n−1]| treated as settled (unsigned).
- `STABLE_CNT`, 32: consecutive settled outputs needed for stability.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: frame request; sampled only in IDLE.
- `in_valid` in 1: source sample strobe (`data_in_valid`).
- `sos_valid` in 1: `data_valid_out` of the last SOS stage.
- `sos_data` in DATA_W signed: last-stage output sample.
- `flush` out 1: one-cycle clear of all SOS delay/pipe registers.
- `sample_en` out 1: gated input strobe to stage 0.
- `busy` out 1: frame in progress.
- `addr` out ADDR_W: index of the output currently flagged by `out_valid`.
- `out_valid` out 1: accepted output strobe (`data_out_valid`).
- `filter_done` out 1: one-cycle frame-complete pulse.
- `timeout` out 1: sticky; set when DRAIN expires.
- `stable_out` out 1: sticky stability flag.

## Operation
- The FSM has five states: IDLE → CLEAR → RUN → DRAIN → DONE → IDLE.
- IDLE: waits for `start`=1, then goes to CLEAR. Entering CLEAR clears `in_cnt`, `out_cnt`, `timeout` and `stable_out`.
- CLEAR: lasts exactly one cycle with `flush`=1, then goes to RUN.
- RUN:
  - `sample_en` = `in_valid` (combinational). Each accepted sample increments `in_cnt`.
  - When the sample that makes `in_cnt`=`N_SAMPLES` is accepted, the FSM goes to DRAIN.
  - `in_valid` outside RUN is ignored (`sample_en`=0).
- Output side, in RUN and DRAIN:
  - `out_valid` = `sos_valid` (combinational), gated by `out_cnt` < `N_SAMPLES`.
  - `addr` = `out_cnt`. `out_cnt` increments on each `out_valid`.
  - Extra `sos_valid` pulses beyond `N_SAMPLES` are dropped.
- DRAIN:
  - Goes to DONE when `out_cnt` reaches `N_SAMPLES`.
  - A drain counter clears on DRAIN entry. If it reaches `DRAIN_MAX` first, `timeout` is set and the FSM goes to DONE.
- DONE: asserts `filter_done`=1 for one cycle, then returns to IDLE.
- `busy` = 1 in every state except IDLE.
- `start` while `busy` is ignored. `start` coinciding with the DONE cycle is also ignored.
- An output arriving on the same cycle as the last input is counted normally.
- Reset value of every output is 0. Assertion of `rst_n` mid-frame aborts to IDLE immediately.

## Timing
- Start at edge t: CLEAR in cycle t+1 (`flush`=1), RUN from t+2. The first `sample_en` occurs at t+2 at the earliest.
- `sample_en`, `out_valid` and `addr` are zero-latency (combinational from registered state/counters).
- `filter_done` is registered. It rises one cycle after the edge that consumes the last output, or one cycle after the timeout edge.
- `flush` and `filter_done` are always exactly one cycle wide.
- `stable_out` rises on the edge that consumes the `STABLE_CNT`-th consecutive settled output. It stays high until the next CLEAR or reset.

## Configuration
- `IIR_STABLE_DET_EN` defined:
  - A registered previous-output value and a run counter are built.
  - The difference is computed at DATA_W+1 bits signed, then its absolute value is taken.
  - Any output with |diff| > `STABLE_THR` resets the run counter to 0. The run counter saturates at `STABLE_CNT`.
  - The first output of a frame has no previous value: it only loads the register and does not count.
- `IIR_STABLE_DET_EN` undefined: `stable_out` is tied to 0 and none of the above logic exists.

## Structure
- Shared package `iir_pkg`:
  - FSM state enum `seq_state_t` with values IDLE, CLEAR, RUN, DRAIN, DONE.
  - Default constants `IIR_N_SAMPLES`, `IIR_ADDR_W`, `IIR_DATA_W`.
- One sub-module, `iir_stable_det`, holds the stability logic.
  - Ports: clk, rst_n, clr, valid, data, stable.
  - Instantiated only under `IIR_STABLE_DET_EN`.

## Test plan
- Basic frame: reset, start, 2048 back-to-back `in_valid`, SOS model with 3-cycle latency → `flush` one cycle at t+1. Expect 2048 `sample_en`, `addr` running 0..2047, a single `filter_done` 4 cycles after the last input, `timeout`=0.
- Bursty input: `in_valid` 50% random, `N_SAMPLES`=16 → exactly 16 `sample_en` and 16 `out_valid`. `in_valid` after the 16th sample yields no `sample_en`.
- Lost outputs: model drops 2 outputs, `DRAIN_MAX`=64 → `timeout`=1, `filter_done` 65 cycles after DRAIN entry, `addr` stops at 13.
- Start abuse: `start` held high through the frame and pulsed again during DONE → exactly one frame, no restart until IDLE.
- Mid-frame reset: `rst_n`=0 at sample 100 → all outputs 0 immediately. A new start after reset re-runs the frame with `addr` beginning at 0.
- Stability (`IIR_STABLE_DET_EN`): constant output 1000 with ±5 jitter → `stable_out`=1 on the 33rd output (first sample + 32 settled). A step of 500 before that restarts the count. Without the macro, `stable_out` stays 0 throughout.
